// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The default fetch_entry_t matches the default top-level widths; the top
// declares its own entry type when it is built with other widths.
package fetch_pkg;

  localparam int PC_INC       = 4;
  localparam int FETCH_PERF_W = 16;
  localparam int FETCH_PC_W   = 8;
  localparam int FETCH_INS_W  = 32;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

  // Saturating increment for the stall counter.
  function automatic logic [FETCH_PERF_W-1:0] sat_inc(input logic [FETCH_PERF_W-1:0] v);
    logic [FETCH_PERF_W-1:0] r;
    if (v == {FETCH_PERF_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + FETCH_PERF_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, flush and occupancy.
// Pointers are log2(DEPTH) bits and wrap naturally; a flush empties the
// queue and takes priority over any push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  entry_t           wdata_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_s;
  logic               do_pop_s;

  // Next-state computation for pointers and occupancy.
  always_comb begin
    do_push_s = push_i & ~flush_i;
    do_pop_s  = pop_i & (count_q != CNT_W'(0)) & ~flush_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers and entry storage (storage cleared on reset
  // so the head reads as zero out of reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues reads to a one-cycle
// latency instruction memory and queues {pc, instr} pairs for the datapath.
// Optional feature macro: FETCH_PERF_CNT_EN adds the perf_stall_cnt output
// (cycles where the consumer was ready but no instruction was available).
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [INS_W-1:0]        imem_rdata,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INS_W-1:0]        out_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [FETCH_PERF_W-1:0] perf_stall_cnt,
`endif
  output logic [PC_W-1:0]         out_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;

  logic [CNT_W-1:0] fifo_count_s;
  logic [OCC_W-1:0] occupancy_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  entry_t           push_entry_s;
  entry_t           head_s;

  // Credit check: queued entries plus the outstanding request must leave a
  // free slot, so a returning response can always be written.
  always_comb begin
    occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_q);
    issue_s     = (occupancy_s < OCC_W'(DEPTH)) & ~redirect_valid & ~reset;
  end

  // Response/pop control and head handshake.
  always_comb begin
    push_s             = inflight_q & ~kill_q & ~redirect_valid;
    pop_s              = out_valid & out_ready;
    push_entry_s.pc    = req_pc_q;
    push_entry_s.instr = imem_rdata;
  end

  // Next PC, request PC and outstanding-request tracking. kill marks a
  // response that belongs to a request older than the latest redirect.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue_s;
    kill_d     = redirect_valid & inflight_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      req_pc_d   = req_pc_q;
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
      req_pc_d   = fetch_pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
    end
  end

  // PC and request-tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= PC_W'(0);
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect_valid),
    .wdata_i (push_entry_s),
    .rdata_o (head_s),
    .count_o (fifo_count_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (fifo_count_s != CNT_W'(0));
  assign out_pc    = head_s.pc;
  assign out_instr = head_s.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [FETCH_PERF_W-1:0] perf_q;

  // Stall counter: consumer ready with nothing to deliver; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= FETCH_PERF_W'(0);
    end else if (out_ready && !out_valid) begin
      perf_q <= sat_inc(perf_q);
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed timing checks plus a
// randomized phase, with a stream-level reference model in a scoreboard.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;

  instr_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // Instruction memory: one-cycle latency, garbage when not read.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the program stream expected at the output, i.e. the
  // sequential PCs from the most recent restart point (reset or redirect).
  logic [7:0]  exp_q[$];
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_pc;
  logic [31:0] prev_instr;

  task automatic refill(input logic [7:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 8'(4 * i));
  endtask

  // Monitor: compares every accepted head against the model, checks head
  // stability under backpressure, and restarts the model on reset/redirect.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      refill(8'h00);
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_pc", {24'd0, out_pc}, {24'd0, prev_pc});
        chk("hold_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", {24'd0, out_pc}, {24'd0, e});
          chk("out_instr", out_instr, mem_word(e));
          exp_q.push_back(exp_q[$] + 8'd4);
        end
      end
      prev_hold  = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      if (redirect_valid) refill(redirect_pc & 8'hFC);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n_iss;
    int hs0;
    logic [7:0] last_addr;
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    repeat (3) @(posedge clk);

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_out_pc", {24'd0, out_pc}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf", {16'd0, perf_stall_cnt}, 32'd0);
`endif

    // Cold start with out_ready=1
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", {24'd0, imem_addr}, 32'h00);
    step(); @(negedge clk);
    chk("c1_addr", {24'd0, imem_addr}, 32'h04);
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    step(); @(negedge clk);
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_pc", {24'd0, out_pc}, 32'h00);
`ifdef FETCH_PERF_CNT_EN
    chk("c2_perf", {16'd0, perf_stall_cnt}, 32'd2);
`endif
    for (int i = 0; i < 16; i++) begin
      step(); @(negedge clk);
      chk("tput_valid", {31'd0, out_valid}, 32'd1);
      chk("tput_req", {31'd0, imem_req}, 32'd1);
    end

    // Backpressure from reset: exactly DEPTH issues, head stable
    out_ready = 1'b0;
    do_reset();
    n_iss = 0;
    last_addr = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) begin
        n_iss++;
        last_addr = imem_addr;
      end
      step();
    end
    chk("stall_issues", n_iss, 32'd4);
    chk("stall_last_addr", {24'd0, last_addr}, 32'h0C);
    @(negedge clk);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_head", {24'd0, out_pc}, 32'h00);
    step();
    out_ready = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) n_iss++;
      step();
    end
    chk("drain_resume", {31'd0, n_iss > 0}, 32'd1);

    // Redirect with 3 queued + 1 in flight
    out_ready = 1'b0;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 8'h41;
    @(negedge clk);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("r1_req", {31'd0, imem_req}, 32'd1);
    chk("r1_addr", {24'd0, imem_addr}, 32'h40);
    chk("r1_valid", {31'd0, out_valid}, 32'd0);
    step(); @(negedge clk);
    chk("r2_valid", {31'd0, out_valid}, 32'd0);
    step(); @(negedge clk);
    chk("r3_valid", {31'd0, out_valid}, 32'd1);
    chk("r3_pc", {24'd0, out_pc}, 32'h40);
    step();
    out_ready = 1'b1;
    repeat (10) step();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    @(negedge clk);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr0", {24'd0, imem_addr}, 32'hFC);
    step(); @(negedge clk);
    chk("wrap_req1", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr1", {24'd0, imem_addr}, 32'h00);
    repeat (8) step();

    // One-cycle reset while a request is outstanding
    @(negedge clk);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("rr_c0_valid", {31'd0, out_valid}, 32'd0);
    step(); @(negedge clk);
    chk("rr_c1_valid", {31'd0, out_valid}, 32'd0);
    step(); @(negedge clk);
    chk("rr_c2_valid", {31'd0, out_valid}, 32'd1);
    chk("rr_c2_pc", {24'd0, out_pc}, 32'h00);

    // Randomized backpressure and redirects
    hs0 = hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc = 8'($urandom);
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("rand_progress", {31'd0, (hs_cnt - hs0) > 500}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
    // Forced long stall saturates the counter
    redirect_valid = 1'b1;
    out_ready = 1'b1;
    repeat (70000) step();
    @(negedge clk);
    chk("perf_sat", {16'd0, perf_stall_cnt}, 32'h0000FFFF);
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
